// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM encoding,
// default memory geometry and the byte-address to word-index mapping.
package mem_access_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_ADDR_BASE = 1024;
   localparam int DEF_MEM_DEPTH = 64;

   // Word index of a byte address relative to the base; the low two bits are dropped.
   function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/mem_access_stage_data_memory.sv
// Single-port word-addressed data memory with synchronous write and a
// registered read. Contents are not reset.
module data_memory
   import mem_access_stage_pkg::*;
#(
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [MEM_DEPTH];

   // write the addressed word on we, register the addressed word on re
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: holds the execute results in the EXE/MEM
// register, performs a fixed-latency load or store, stalls upstream while
// the access is in flight and hands writeback one enabled cycle per instruction.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
   parameter int ADDR_BASE   = DEF_ADDR_BASE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WB_en_in,
   input  logic        MEM_r_en_in,
   input  logic        MEM_w_en_in,
   input  logic [3:0]  dest_in,
   input  logic [31:0] alu_res_in,
   input  logic [31:0] val_rm_in,
   output logic        freeze,
   output logic        WB_en_out,
   output logic        MEM_r_en_out,
   output logic [3:0]  dest_out,
   output logic [31:0] alu_res_out,
   output logic [31:0] mem_data_out
);

   localparam int         ADDR_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   logic              wb_en_p0;
   logic              r_en_p0;
   logic              w_en_p0;
   logic [3:0]        dest_p0;
   logic [31:0]       alu_res_p0;
   logic [31:0]       val_rm_p0;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        cnt;
   logic [3:0]        cnt_nxt;

   logic              mem_op;
   logic              access_edge;
   logic              in_range;
   logic [31:0]       idx;
   logic              mem_we;
   logic              mem_re;
   logic              rd_ok;
   logic [31:0]       rd_data;

   // EXE/MEM stage register: takes a new instruction whenever the stage is not stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en_p0   <= 1'b0;
         r_en_p0    <= 1'b0;
         w_en_p0    <= 1'b0;
         dest_p0    <= '0;
         alu_res_p0 <= '0;
         val_rm_p0  <= '0;
      end else if (!freeze) begin
         wb_en_p0   <= WB_en_in;
         r_en_p0    <= MEM_r_en_in;
         w_en_p0    <= MEM_w_en_in;
         dest_p0    <= dest_in;
         alu_res_p0 <= alu_res_in;
         val_rm_p0  <= val_rm_in;
      end
   end

   assign mem_op      = r_en_p0 | w_en_p0;
   assign freeze      = mem_op & (state != DONE);
   assign idx         = word_index(alu_res_p0, 32'(ADDR_BASE));
   assign in_range    = (alu_res_p0 >= 32'(ADDR_BASE)) && (idx < 32'(MEM_DEPTH));
   assign access_edge = (state == BUSY) && (cnt == '0);

   // Reset on the access edge abandons the access; store wins over a simultaneous load.
   assign mem_we = ~rst & access_edge & w_en_p0 & in_range;
   assign mem_re = ~rst & access_edge & r_en_p0 & ~w_en_p0 & in_range;

   // FSM state and latency counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next-state logic: IDLE -> BUSY for WAIT_CYCLES edges -> DONE -> IDLE
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (mem_op) begin
               state_nxt = BUSY;
               cnt_nxt   = CNT_INIT;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // remember whether the latest completed load returned real memory data (else it reads 0)
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ok <= 1'b0;
      end else if (access_edge && r_en_p0) begin
         rd_ok <= mem_re;
      end
   end

   data_memory #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_data_memory (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (idx[ADDR_W-1:0]),
      .wdata (val_rm_p0),
      .rdata (rd_data)
   );

   assign WB_en_out    = wb_en_p0 & ~freeze;
   assign MEM_r_en_out = r_en_p0;
   assign dest_out     = dest_p0;
   assign alu_res_out  = alu_res_p0;
   assign mem_data_out = rd_ok ? rd_data : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a table of directed vectors,
// hand-written multi-cycle sequences and random traffic against a
// behavioural model of memory contents and per-instruction latency.
module tb_mem_access_stage;

   localparam int ADDR_BASE = 1024;
   localparam int DEPTH     = 64;

   typedef struct {
      logic        wb;
      logic        rd;
      logic        wr;
      logic [3:0]  dest;
      logic [31:0] alu;
      logic [31:0] val;
   } op_t;

   typedef struct {
      op_t         op;
      int          frz;
      logic        wb;
      logic [31:0] data;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_i   [3];
   logic        rd_i   [3];
   logic        wr_i   [3];
   logic [3:0]  dest_i [3];
   logic [31:0] alu_i  [3];
   logic [31:0] val_i  [3];
   logic        frz_o  [3];
   logic        wb_o   [3];
   logic        rd_o   [3];
   logic [3:0]  dest_o [3];
   logic [31:0] alu_o  [3];
   logic [31:0] data_o [3];

   int          n_vec = 0;
   int          n_bad = 0;

   int          wc [3] = '{2, 1, 15};
   logic [31:0] model_mem  [3][DEPTH];
   logic [31:0] model_last [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_access_stage #(
         .WAIT_CYCLES (g == 0 ? 2 : (g == 1 ? 1 : 15)),
         .MEM_DEPTH   (DEPTH),
         .ADDR_BASE   (ADDR_BASE)
      ) dut (
         .clk          (clk),
         .rst          (rst),
         .WB_en_in     (wb_i[g]),
         .MEM_r_en_in  (rd_i[g]),
         .MEM_w_en_in  (wr_i[g]),
         .dest_in      (dest_i[g]),
         .alu_res_in   (alu_i[g]),
         .val_rm_in    (val_i[g]),
         .freeze       (frz_o[g]),
         .WB_en_out    (wb_o[g]),
         .MEM_r_en_out (rd_o[g]),
         .dest_out     (dest_o[g]),
         .alu_res_out  (alu_o[g]),
         .mem_data_out (data_o[g])
      );
   end

   function automatic op_t mk(input logic wb, input logic rd, input logic wr,
                              input logic [3:0] d, input logic [31:0] a, input logic [31:0] v);
      op_t o;
      o.wb = wb; o.rd = rd; o.wr = wr; o.dest = d; o.alu = a; o.val = v;
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int k, input op_t o);
      wb_i[k] = o.wb; rd_i[k] = o.rd; wr_i[k] = o.wr;
      dest_i[k] = o.dest; alu_i[k] = o.alu; val_i[k] = o.val;
   endtask

   // Reference model: memory effect and expected freeze cycles / load result of one instruction.
   task automatic model_op(input int k, input op_t o, output int exp_frz, output logic [31:0] exp_data);
      longint a;
      longint w;
      bit     ok;
      a  = longint'(o.alu);
      w  = (a - ADDR_BASE) / 4;
      ok = (a >= ADDR_BASE) && (w < DEPTH);
      exp_frz = (o.rd || o.wr) ? wc[k] + 1 : 0;
      if (o.wr && ok) model_mem[k][int'(w)] = o.val;
      if (o.rd) model_last[k] = (o.wr || !ok) ? 32'h0 : model_mem[k][int'(w)];
      exp_data = model_last[k];
   endtask

   // Apply one instruction when the stage is ready, wait out its stall, check its writeback cycle.
   task automatic run_check(input int k, input op_t o, input int exp_frz, input logic exp_wb,
                            input logic [31:0] exp_data, input string name);
      int n;
      int leaks;
      drive(k, o);
      @(posedge clk); #1;
      n = 0;
      leaks = 0;
      while (frz_o[k] && n < 100) begin
         if (wb_o[k]) leaks++;
         n++;
         @(posedge clk); #1;
      end
      chk({name, "_freeze_cycles"}, n, exp_frz);
      chk({name, "_wb_while_frozen"}, leaks, 0);
      chk({name, "_wb_en"}, {31'b0, wb_o[k]}, {31'b0, exp_wb});
      chk({name, "_dest"}, {28'b0, dest_o[k]}, {28'b0, o.dest});
      chk({name, "_alu_res"}, alu_o[k], o.alu);
      chk({name, "_r_en"}, {31'b0, rd_o[k]}, {31'b0, o.rd});
      chk({name, "_mem_data"}, data_o[k], exp_data);
      drive(k, mk(0, 0, 0, 4'd0, 32'h0, 32'h0));
   endtask

   task automatic model_run(input int k, input op_t o, input string name);
      int          ef;
      logic [31:0] ed;
      model_op(k, o, ef, ed);
      run_check(k, o, ef, o.wb, ed, name);
   endtask

   initial begin
      vec_t        tbl [$];
      int          ef;
      int          n;
      logic [31:0] ed;
      op_t         o;
      op_t         o2;

      for (int k = 0; k < 3; k++) begin
         drive(k, mk(0, 0, 0, 4'd0, 32'h0, 32'h0));
         model_last[k] = 32'h0;
      end

      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_freeze", {31'b0, frz_o[0]}, 32'h0);
      chk("reset_wb_en", {31'b0, wb_o[0]}, 32'h0);
      chk("reset_mem_data", data_o[0], 32'h0);
      chk("reset_dest", {28'b0, dest_o[0]}, 32'h0);
      chk("reset_alu_res", alu_o[0], 32'h0);

      // directed table (WAIT_CYCLES=2 instance)
      tbl.push_back('{mk(1, 0, 0, 4'd4, 32'h55,  32'h0),        0, 1'b1, 32'h0});
      tbl.push_back('{mk(0, 0, 1, 4'd0, 32'd1028, 32'hDEADBEEF), 3, 1'b0, 32'h0});
      tbl.push_back('{mk(1, 1, 0, 4'd7, 32'd1028, 32'h0),        3, 1'b1, 32'hDEADBEEF});
      tbl.push_back('{mk(0, 0, 1, 4'd0, 32'd1024, 32'hA5A5A5A5), 3, 1'b0, 32'hDEADBEEF});
      tbl.push_back('{mk(0, 0, 1, 4'd0, 32'd1276, 32'h5A5A5A5A), 3, 1'b0, 32'hDEADBEEF});
      tbl.push_back('{mk(0, 0, 1, 4'd0, 32'd1020, 32'h11111111), 3, 1'b0, 32'hDEADBEEF});
      tbl.push_back('{mk(0, 0, 1, 4'd0, 32'd1280, 32'h22222222), 3, 1'b0, 32'hDEADBEEF});
      tbl.push_back('{mk(1, 1, 0, 4'd2, 32'd1020, 32'h0),        3, 1'b1, 32'h0});
      tbl.push_back('{mk(1, 1, 0, 4'd1, 32'd1024, 32'h0),        3, 1'b1, 32'hA5A5A5A5});
      tbl.push_back('{mk(1, 1, 0, 4'd5, 32'd1276, 32'h0),        3, 1'b1, 32'h5A5A5A5A});
      tbl.push_back('{mk(1, 1, 0, 4'd3, 32'd1031, 32'h0),        3, 1'b1, 32'hDEADBEEF});
      tbl.push_back('{mk(1, 1, 1, 4'd8, 32'd1032, 32'h77),       3, 1'b1, 32'h0});
      tbl.push_back('{mk(1, 1, 0, 4'd8, 32'd1032, 32'h0),        3, 1'b1, 32'h77});
      tbl.push_back('{mk(0, 0, 0, 4'd6, 32'hFFFFFFFF, 32'h0),    0, 1'b0, 32'h77});
      for (int i = 0; i < tbl.size(); i++) begin
         model_op(0, tbl[i].op, ef, ed);
         run_check(0, tbl[i].op, tbl[i].frz, tbl[i].wb, tbl[i].data, $sformatf("tbl%0d", i));
      end

      // fill every word so later loads have known contents
      for (int i = 0; i < DEPTH; i++) begin
         model_run(0, mk(0, 0, 1, 4'd0, 32'(ADDR_BASE + 4 * i), $urandom), $sformatf("fill%0d", i));
      end

      // reset while a store is in flight: the store must not land
      o = mk(0, 0, 1, 4'd0, 32'(ADDR_BASE + 4 * 5), 32'hBAD0BAD0);
      drive(0, o);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(0, mk(0, 0, 0, 4'd0, 32'h0, 32'h0));
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) model_last[k] = 32'h0;
      chk("busy_reset_freeze", {31'b0, frz_o[0]}, 32'h0);
      chk("busy_reset_wb_en", {31'b0, wb_o[0]}, 32'h0);
      chk("busy_reset_mem_data", data_o[0], 32'h0);
      model_run(0, mk(1, 1, 0, 4'd5, 32'(ADDR_BASE + 4 * 5), 32'h0), "busy_reset_word");

      // load followed by ALU op whose inputs appear while the stage is frozen
      o  = mk(1, 1, 0, 4'd3, 32'(ADDR_BASE + 40), 32'h0);
      o2 = mk(1, 0, 0, 4'd9, 32'h1234, 32'h0);
      model_op(0, o, ef, ed);
      drive(0, o);
      @(posedge clk); #1;
      drive(0, o2);
      n = 0;
      while (frz_o[0] && n < 100) begin
         chk("b2b_hold_dest", {28'b0, dest_o[0]}, 32'd3);
         n++;
         @(posedge clk); #1;
      end
      chk("b2b_load_freeze", n, ef);
      chk("b2b_load_wb", {31'b0, wb_o[0]}, 32'h1);
      chk("b2b_load_dest", {28'b0, dest_o[0]}, 32'd3);
      chk("b2b_load_data", data_o[0], ed);
      model_op(0, o2, ef, ed);
      @(posedge clk); #1;
      drive(0, mk(0, 0, 0, 4'd0, 32'h0, 32'h0));
      chk("b2b_alu_freeze", {31'b0, frz_o[0]}, 32'h0);
      chk("b2b_alu_wb", {31'b0, wb_o[0]}, 32'h1);
      chk("b2b_alu_dest", {28'b0, dest_o[0]}, 32'd9);
      chk("b2b_alu_res", alu_o[0], 32'h1234);
      chk("b2b_alu_data_held", data_o[0], ed);
      @(posedge clk); #1;

      // random traffic against the model
      for (int i = 0; i < 150; i++) begin
         int          kind;
         logic [31:0] addr;
         kind = $urandom_range(0, 7);
         if ($urandom_range(0, 7) == 0) begin
            addr = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, ADDR_BASE - 1))
                                               : 32'(ADDR_BASE + 4 * DEPTH + $urandom_range(0, 4096));
         end else begin
            addr = 32'(ADDR_BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3));
         end
         o = mk(1'($urandom_range(0, 1)),
                (kind == 2 || kind == 3 || kind == 7) ? 1'b1 : 1'b0,
                (kind == 4 || kind == 5 || kind == 7) ? 1'b1 : 1'b0,
                4'($urandom_range(0, 15)), addr, $urandom);
         model_run(0, o, $sformatf("rnd%0d", i));
      end

      // latency extremes: last word on WAIT_CYCLES=1 and WAIT_CYCLES=15 instances
      for (int k = 1; k < 3; k++) begin
         model_run(k, mk(0, 0, 1, 4'd0, 32'(ADDR_BASE + 4 * 63), 32'hC0DE0000 + 32'(k)),
                   $sformatf("wc%0d_store", wc[k]));
         model_op(k, mk(1, 1, 0, 4'd12, 32'(ADDR_BASE + 4 * 63), 32'h0), ef, ed);
         run_check(k, mk(1, 1, 0, 4'd12, 32'(ADDR_BASE + 4 * 63), 32'h0),
                   (k == 1) ? 2 : 16, 1'b1, 32'hC0DE0000 + 32'(k), $sformatf("wc%0d_load", wc[k]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
